// File: rtl/shift_register_sipo_rx_pkg.sv
// Shared types and helpers for the SIPO receive path.
package shift_register_sipo_rx_pkg;

   typedef enum logic {
      ACC = 1'b0,
      PAR = 1'b1
   } sipo_state_e;

   // Width needed to count 0..n inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/shift_register_sipo_rx_shifter.sv
// Plain N-bit left shifter with shift enable, synchronous reset and
// parallel output; the newest bit enters at the LSB.
module shift_register_sipo_rx_shifter #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         din,
   output logic [N-1:0] q
);

   // Shift one bit in whenever enabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         q <= {q[N-2:0], din};
      end
   end

endmodule

// File: rtl/shift_register_sipo_rx.sv
// Serial-in parallel-out receiver: reassembles N-bit words from a serial
// stream and offers them on a valid/ready port with a one-word holding
// register and a sticky overflow flag.
// Optional feature macro: SIPO_PARITY_EN (adds an even-parity bit after
// each word and the PO_err output).
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  ACC   | collecting data bits; count holds the bits taken so far
//  PAR   | N data bits held, waiting for the parity bit (parity build)
module shift_register_sipo_rx
   import shift_register_sipo_rx_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         SI,
   input  logic         SI_valid,
   input  logic         sync,
   output logic [N-1:0] PO,
   output logic         PO_valid,
   input  logic         PO_ready,
   output logic         overflow
`ifdef SIPO_PARITY_EN
   ,
   output logic         PO_err
`endif
);

   localparam int                CNT_W    = cnt_width(N);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

   sipo_state_e      state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [N-1:0]     sh_q;
   logic [N-1:0]     word;
   logic [N-1:0]     po_d;
   logic             po_valid_d;
   logic             overflow_d;
   logic             shift_en;
   logic             last_data;
   logic             complete;
   logic             load;
   logic             drop;

   // Data bits are only shifted while collecting; sync blocks the bit.
   assign shift_en  = SI_valid & ~sync & (state_q == ACC);
   assign last_data = shift_en & (count_q == LAST_BIT);

`ifdef SIPO_PARITY_EN
   logic word_err;
   logic err_d;

   // The parity bit closes the word; it is checked but never shifted in.
   assign complete = SI_valid & ~sync & (state_q == PAR);
   assign word     = sh_q;
   assign word_err = ^{sh_q, SI};
`else
   logic unused_msb;

   // The word closes on the edge that samples data bit N, so the last bit
   // is taken straight from SI to hit single-cycle latency.
   assign complete   = last_data;
   assign word       = {sh_q[N-2:0], SI};
   assign unused_msb = sh_q[N-1];
`endif

   // A completed word lands if the holder is empty or drains on this edge.
   assign load = complete & (~PO_valid | PO_ready);
   assign drop = complete & ~load;

   shift_register_sipo_rx_shifter #(
      .N (N)
   ) u_shifter (
      .clk   (clk),
      .reset (reset),
      .en    (shift_en),
      .din   (SI),
      .q     (sh_q)
   );

   // State, bit counter, holding register and flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ACC;
         count_q  <= '0;
         PO       <= '0;
         PO_valid <= 1'b0;
         overflow <= 1'b0;
`ifdef SIPO_PARITY_EN
         PO_err   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         PO       <= po_d;
         PO_valid <= po_valid_d;
         overflow <= overflow_d;
`ifdef SIPO_PARITY_EN
         PO_err   <= err_d;
`endif
      end
   end

   // Next-state, bit count and output-port update.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      po_d       = PO;
      po_valid_d = PO_valid;
      overflow_d = overflow;
`ifdef SIPO_PARITY_EN
      err_d      = PO_err;
`endif

      if (sync) begin
         state_d = ACC;
         count_d = '0;
      end else if (complete) begin
         state_d = ACC;
         count_d = '0;
`ifdef SIPO_PARITY_EN
      end else if (last_data) begin
         state_d = PAR;
         count_d = '0;
`endif
      end else if (shift_en) begin
         count_d = count_q + CNT_W'(1);
      end

      if (PO_valid & PO_ready) begin
         po_valid_d = 1'b0;
      end

      if (load) begin
         po_d       = word;
         po_valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
         err_d      = word_err;
`endif
      end

      if (drop) begin
         overflow_d = 1'b1;
      end
   end

endmodule

// File: tb/tb_shift_register_sipo_rx.sv
// Bench for shift_register_sipo_rx: directed scenarios followed by random
// traffic, all compared every cycle against a word-level reference model.
module tb_shift_register_sipo_rx;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         SI;
   logic         SI_valid;
   logic         sync;
   logic [N-1:0] PO;
   logic         PO_valid;
   logic         PO_ready;
   logic         overflow;
`ifdef SIPO_PARITY_EN
   logic         PO_err;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: the current word is a list of received bits.
   bit           mq[$];
   bit           m_inpar;
   logic [N-1:0] m_po;
   bit           m_pov;
   bit           m_ovf;
   bit           m_err;

   shift_register_sipo_rx #(.N(N)) dut (
      .clk      (clk),
      .reset    (reset),
      .SI       (SI),
      .SI_valid (SI_valid),
      .sync     (sync),
      .PO       (PO),
      .PO_valid (PO_valid),
      .PO_ready (PO_ready),
      .overflow (overflow)
`ifdef SIPO_PARITY_EN
      ,
      .PO_err   (PO_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk_word({tag, ".PO"}, PO, m_po);
      chk_bit({tag, ".PO_valid"}, PO_valid, m_pov);
      chk_bit({tag, ".overflow"}, overflow, m_ovf);
`ifdef SIPO_PARITY_EN
      chk_bit({tag, ".PO_err"}, PO_err, m_err);
`endif
   endtask

   task automatic do_reset();
      reset = 1'b1; SI = 1'b0; SI_valid = 1'b0; sync = 1'b0; PO_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      mq.delete(); m_inpar = 0; m_po = '0; m_pov = 0; m_ovf = 0; m_err = 0;
      check_all("reset");
   endtask

   task automatic step(input bit si, input bit v, input bit s, input bit r);
      bit           done;
      logic [N-1:0] w;
      bit           e;
      done = 0; w = '0; e = 0;
      SI = si; SI_valid = v; sync = s; PO_ready = r;
      if (s) begin
         mq.delete(); m_inpar = 0;
      end else if (v) begin
         if (m_inpar) begin
            for (int i = 0; i < N; i++) w = {w[N-2:0], mq[i]};
            e = ^{w, si};
            done = 1; mq.delete(); m_inpar = 0;
         end else begin
            mq.push_back(si);
            if (mq.size() == N) begin
`ifdef SIPO_PARITY_EN
               m_inpar = 1;
`else
               for (int i = 0; i < N; i++) w = {w[N-2:0], mq[i]};
               done = 1; mq.delete();
`endif
            end
         end
      end
      if (done) begin
         if (!m_pov || r) begin
            m_po = w; m_pov = 1; m_err = e;
         end else begin
            m_ovf = 1;
         end
      end else if (m_pov && r) begin
         m_pov = 0;
      end
      @(posedge clk); #1;
      check_all("step");
   endtask

   // Send one word MSB first; last_r applies on the completing edge.
   task automatic send_word(input logic [N-1:0] w, input bit r, input bit last_r,
                            input bit gaps, input bit flip);
      for (int i = N - 1; i >= 0; i--) begin
         if (gaps) step(1'b0, 1'b0, 1'b0, r);
`ifdef SIPO_PARITY_EN
         step(w[i], 1'b1, 1'b0, r);
`else
         step(w[i], 1'b1, 1'b0, (i == 0) ? last_r : r);
`endif
      end
`ifdef SIPO_PARITY_EN
      if (gaps) step(1'b0, 1'b0, 1'b0, r);
      step((^w) ^ flip, 1'b1, 1'b0, last_r);
`else
      if (flip) step(1'b0, 1'b0, 1'b0, r);
`endif
   endtask

   initial begin
      do_reset();
      chk_word("reset_po", PO, 8'h00);
      chk_bit("reset_valid", PO_valid, 1'b0);

      // 1 basic
      send_word(8'hB2, 1'b1, 1'b1, 1'b0, 1'b0);
      chk_word("basic_po", PO, 8'hB2);
      chk_bit("basic_valid", PO_valid, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_bit("basic_valid_drop", PO_valid, 1'b0);

      // 2 gaps and backpressure
      send_word(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      chk_word("bp_po", PO, 8'h5A);
      chk_bit("bp_valid", PO_valid, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_bit("bp_drop", PO_valid, 1'b0);

      // 3 overflow
      send_word(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_word("ovf_po", PO, 8'h11);
      chk_bit("ovf_flag", overflow, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk_bit("ovf_drain_valid", PO_valid, 1'b0);
      chk_bit("ovf_sticky", overflow, 1'b1);

      // 4 sync
      do_reset();
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      send_word(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
      chk_word("sync_po", PO, 8'hC3);
      chk_bit("sync_ovf", overflow, 1'b0);

      // 5 completion on the same edge as a consume
      step(1'b0, 1'b0, 1'b0, 1'b1);
      send_word(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(8'h7E, 1'b0, 1'b1, 1'b0, 1'b0);
      chk_word("simul_po", PO, 8'h7E);
      chk_bit("simul_valid", PO_valid, 1'b1);
      chk_bit("simul_ovf", overflow, 1'b0);

      // 6 reset mid-word
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      do_reset();
`ifdef SIPO_PARITY_EN
      send_word(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
      chk_bit("par_bad", PO_err, 1'b1);
      send_word(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
      chk_bit("par_good", PO_err, 1'b0);
`else
      send_word(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
      chk_word("rst_po", PO, 8'hFF);
      chk_bit("rst_ovf", overflow, 1'b0);

      // random traffic, occasional sync and reset
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
